// File: rtl/systolic_pkg.sv
// Shared constants, drain state encoding and index-width helper for the systolic block.
package systolic_pkg;

  localparam int DEF_W = 16;
  localparam int DEF_N = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } drain_state_t;

  function automatic int idx_width(input int n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction

endpackage

// File: rtl/result_drain_if.sv
// Valid/ready element stream out of result_drain.
// Optional RESULT_DRAIN_LAST_EN adds the last-element flag.
interface result_drain_if #(
  parameter int W     = systolic_pkg::DEF_W,
  parameter int N     = systolic_pkg::DEF_N,
  parameter int IDX_W = systolic_pkg::idx_width(N)
);

  logic [W-1:0]     data;
  logic [IDX_W-1:0] idx;
  logic             valid;
  logic             ready;

`ifdef RESULT_DRAIN_LAST_EN
  logic             last;

  modport master (output data, idx, valid, last, input ready);
  modport slave  (input data, idx, valid, last, output ready);
`else
  modport master (output data, idx, valid, input ready);
  modport slave  (input data, idx, valid, output ready);
`endif

endinterface

// File: rtl/result_drain_bank.sv
// One capture bank: N*N elements of W bits, load-enabled, with an element read mux.
module drain_bank #(
  parameter int W     = 16,
  parameter int N     = 3,
  parameter int IDX_W = 4
) (
  input  logic               clk,
  input  logic               load,
  input  logic [W*N*N-1:0]   din,
  input  logic [IDX_W-1:0]   idx,
  output logic [W*N*N-1:0]   q,
  output logic [W-1:0]       elem
);

  always_ff @(posedge clk) begin
    if (load) q <= din;
  end

  always_comb begin
    elem = '0;
    for (int unsigned e = 0; e < N * N; e++) begin
      if (idx == IDX_W'(e)) elem = q[e*W +: W];
    end
  end

endmodule

// File: rtl/result_drain.sv
// Captures the flattened result matrix on a done rise and streams it element by element.
// Optional RESULT_DRAIN_LAST_EN drives res.last on the final element of a frame.
module result_drain
  import systolic_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int N     = DEF_N,
  parameter int IDX_W = idx_width(N)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_done,
  input  logic [W*N*N-1:0] i_C,
  result_drain_if.master   res,
  output logic             o_capture,
  output logic             o_busy,
  output logic             o_overflow
);

  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(N * N - 1);

  drain_state_t     state;
  logic [IDX_W-1:0] k;
  logic             pend_full;
  logic             done_q;

  logic             cap;
  logic             hs;
  logic             last_hs;
  logic             a_load;
  logic             a_from_p;
  logic             p_load;
  logic [W*N*N-1:0] a_din;
  logic [W*N*N-1:0] p_q;
  logic [W*N*N-1:0] a_flat_unused;
  logic [W-1:0]     a_elem;
  logic [W-1:0]     p_elem_unused;

  assign cap     = i_done & ~done_q;
  assign hs      = (state == STREAM) & res.ready;
  assign last_hs = hs & (k == K_LAST);

  // On the final handshake A refills from P if pending, else straight from i_C;
  // P can only take a new frame while it is empty or being emptied into A.
  always_comb begin
    a_load   = 1'b0;
    a_from_p = 1'b0;
    p_load   = 1'b0;
    case (state)
      IDLE:   a_load = cap;
      STREAM: begin
        if (last_hs) begin
          a_load   = pend_full | cap;
          a_from_p = pend_full;
          p_load   = pend_full & cap;
        end else begin
          p_load   = cap & ~pend_full;
        end
      end
      default: ;
    endcase
  end

  assign a_din = a_from_p ? p_q : i_C;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      k          <= '0;
      pend_full  <= 1'b0;
      done_q     <= 1'b0;
      o_capture  <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      done_q    <= i_done;
      o_capture <= 1'b0;
      case (state)
        IDLE: begin
          if (cap) begin
            state     <= STREAM;
            k         <= '0;
            o_capture <= 1'b1;
          end
        end
        STREAM: begin
          if (last_hs) begin
            k <= '0;
            if (pend_full) begin
              pend_full <= cap;
              o_capture <= cap;
            end else if (cap) begin
              o_capture <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            if (hs) k <= k + 1'b1;
            if (cap) begin
              if (pend_full) begin
                o_overflow <= 1'b1;
              end else begin
                pend_full <= 1'b1;
                o_capture <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  drain_bank #(.W(W), .N(N), .IDX_W(IDX_W)) u_bank_a (
    .clk  (i_clk),
    .load (a_load),
    .din  (a_din),
    .idx  (k),
    .q    (a_flat_unused),
    .elem (a_elem)
  );

  drain_bank #(.W(W), .N(N), .IDX_W(IDX_W)) u_bank_p (
    .clk  (i_clk),
    .load (p_load),
    .din  (i_C),
    .idx  (k),
    .q    (p_q),
    .elem (p_elem_unused)
  );

  assign res.valid = (state == STREAM);
  assign res.idx   = k;
  assign res.data  = (state == STREAM) ? a_elem : '0;
  assign o_busy    = (state == STREAM) | pend_full;

`ifdef RESULT_DRAIN_LAST_EN
  assign res.last  = (state == STREAM) & (k == K_LAST);
`endif

endmodule

// File: tb/tb_result_drain.sv
// Scoreboard bench for result_drain; checks res.last too when RESULT_DRAIN_LAST_EN is defined.
module tb_result_drain;
  import systolic_pkg::*;

  localparam int W     = DEF_W;
  localparam int N     = DEF_N;
  localparam int NN    = N * N;
  localparam int IDX_W = idx_width(N);

  logic              clk = 1'b0;
  logic              rst;
  logic              done;
  logic [W*NN-1:0]   c;
  logic              capture;
  logic              busy;
  logic              overflow;

  int checks   = 0;
  int failures = 0;
  logic [IDX_W+W-1:0] sb[$];

  result_drain_if #(.W(W), .N(N), .IDX_W(IDX_W)) res ();

  result_drain #(.W(W), .N(N), .IDX_W(IDX_W)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_done     (done),
    .i_C        (c),
    .res        (res),
    .o_capture  (capture),
    .o_busy     (busy),
    .o_overflow (overflow)
  );

  always #5 clk = ~clk;

  // Stream monitor: every presented element must match the scoreboard head; pop on handshake.
  always @(negedge clk) begin
    logic [IDX_W+W-1:0] exp;
    if (!rst && res.valid) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output got idx=%0d data=%0h, required no output", res.idx, res.data);
      end else begin
        exp = sb[0];
        if ({res.idx, res.data} !== exp) begin
          failures++;
          $display("FAIL stream_elem got idx=%0d data=%0h, required idx=%0d data=%0h",
                   res.idx, res.data, exp[W +: IDX_W], exp[W-1:0]);
        end
`ifdef RESULT_DRAIN_LAST_EN
        checks++;
        if (res.last !== (exp[W +: IDX_W] == IDX_W'(NN - 1))) begin
          failures++;
          $display("FAIL last_flag got %b at idx=%0d", res.last, exp[W +: IDX_W]);
        end
`endif
        if (res.ready) void'(sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present_frame(input int base, input bit rnd, input bit accept);
    for (int e = 0; e < NN; e++) begin
      logic [W-1:0] v;
      v = rnd ? W'($urandom) : W'(base + e);
      c[e*W +: W] = v;
      if (accept) sb.push_back({IDX_W'(e), v});
    end
    done = 1'b1;
  endtask

  task automatic wait_idx(input logic [IDX_W-1:0] t);
    for (int i = 0; i < 40 && res.idx !== t; i++) step();
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 80 && sb.size() != 0; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; done = 1'b0; c = '0; res.ready = 1'b0;
    repeat (3) step();
    checks++; if (res.valid !== 1'b0) begin failures++; $display("FAIL rst_valid got %b want 0", res.valid); end
    checks++; if (res.idx !== '0) begin failures++; $display("FAIL rst_idx got %0d want 0", res.idx); end
    checks++; if (res.data !== '0) begin failures++; $display("FAIL rst_data got %0h want 0", res.data); end
    checks++; if (capture !== 1'b0) begin failures++; $display("FAIL rst_capture got %b want 0", capture); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow got %b want 0", overflow); end
`ifdef RESULT_DRAIN_LAST_EN
    checks++; if (res.last !== 1'b0) begin failures++; $display("FAIL rst_last got %b want 0", res.last); end
`endif
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_frame();
    res.ready = 1'b1;
    present_frame(1, 1'b0, 1'b1);
    step();
    checks++; if (capture !== 1'b1) begin failures++; $display("FAIL single_capture got %b want 1", capture); end
    checks++; if (res.data !== W'(1)) begin failures++; $display("FAIL single_first got %0h want 1", res.data); end
    step();
    checks++; if (capture !== 1'b0) begin failures++; $display("FAIL single_pulse_width got %b want 0", capture); end
    wait_drain();
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL single_drain left=%0d want 0", sb.size()); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got %b want 0", busy); end
    step(); step();
    checks++; if (res.valid !== 1'b0) begin failures++; $display("FAIL held_done_retrigger valid=%b want 0", res.valid); end
    done = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    logic [3:0] pat;
    pat = 4'b1001;
    res.ready = 1'b0;
    present_frame(20, 1'b0, 1'b1);
    step();
    done = 1'b0;
    for (int i = 0; i < 80 && sb.size() != 0; i++) begin
      res.ready = pat[i % 4];
      step();
    end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL bp_drain left=%0d want 0", sb.size()); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_busy_end got %b want 0", busy); end
    res.ready = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    int bubbles;
    bubbles = 0;
    res.ready = 1'b1;
    present_frame(100, 1'b0, 1'b1);
    step();
    done = 1'b0;
    wait_idx(IDX_W'(3));
    checks++; if (res.idx !== IDX_W'(3)) begin failures++; $display("FAIL b2b_reach_k3 got %0d want 3", res.idx); end
    present_frame(200, 1'b1, 1'b1);
    step();
    checks++; if (capture !== 1'b1) begin failures++; $display("FAIL b2b_capture got %b want 1", capture); end
    done = 1'b0;
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      if (res.valid !== 1'b1) bubbles++;
      step();
    end
    checks++; if (bubbles != 0) begin failures++; $display("FAIL b2b_bubble got %0d want 0", bubbles); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL b2b_drain left=%0d want 0", sb.size()); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL b2b_overflow got %b want 0", overflow); end
    step();
  endtask

  task automatic test_simultaneous();
    res.ready = 1'b1;
    present_frame(300, 1'b0, 1'b1);
    step();
    done = 1'b0;
    wait_idx(IDX_W'(NN - 1));
    present_frame(400, 1'b0, 1'b1);
    step();
    checks++; if (capture !== 1'b1) begin failures++; $display("FAIL sim_empty_capture got %b want 1", capture); end
    checks++; if (res.idx !== '0 || res.data !== W'(400)) begin
      failures++; $display("FAIL sim_empty_switch got idx=%0d data=%0h want idx=0 data=190", res.idx, res.data);
    end
    done = 1'b0;
    wait_drain();
    step();
    present_frame(500, 1'b0, 1'b1);
    step();
    done = 1'b0;
    wait_idx(IDX_W'(2));
    present_frame(600, 1'b1, 1'b1);
    step();
    done = 1'b0;
    wait_idx(IDX_W'(NN - 1));
    present_frame(700, 1'b0, 1'b1);
    step();
    checks++; if (capture !== 1'b1) begin failures++; $display("FAIL sim_full_capture got %b want 1", capture); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL sim_full_busy got %b want 1", busy); end
    done = 1'b0;
    wait_drain();
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL sim_drain left=%0d want 0", sb.size()); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL sim_overflow got %b want 0", overflow); end
    step();
  endtask

  task automatic test_overflow();
    res.ready = 1'b0;
    present_frame(800, 1'b0, 1'b1);
    step(); done = 1'b0; step();
    present_frame(900, 1'b0, 1'b1);
    step();
    checks++; if (capture !== 1'b1) begin failures++; $display("FAIL ovf_second_capture got %b want 1", capture); end
    done = 1'b0; step();
    present_frame(1000, 1'b0, 1'b0);
    step();
    checks++; if (capture !== 1'b0) begin failures++; $display("FAIL ovf_drop_capture got %b want 0", capture); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got %b want 1", overflow); end
    done = 1'b0; step();
    res.ready = 1'b1;
    wait_drain();
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL ovf_drain left=%0d want 0", sb.size()); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ovf_busy_end got %b want 0", busy); end
    step();
  endtask

  task automatic test_reset_mid();
    int idle_valid;
    idle_valid = 0;
    res.ready = 1'b1;
    present_frame(1100, 1'b0, 1'b1);
    step(); done = 1'b0;
    wait_idx(IDX_W'(2));
    present_frame(1200, 1'b0, 1'b1);
    step(); done = 1'b0;
    wait_idx(IDX_W'(4));
    checks++; if (res.idx !== IDX_W'(4) || busy !== 1'b1) begin
      failures++; $display("FAIL mid_setup got idx=%0d busy=%b want idx=4 busy=1", res.idx, busy);
    end
    rst = 1'b1; res.ready = 1'b0;
    step();
    sb.delete();
    checks++; if (res.valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got %b want 0", res.valid); end
    checks++; if (busy !== 1'b0 || overflow !== 1'b0) begin
      failures++; $display("FAIL mid_rst_flags got busy=%b ovf=%b want 0 0", busy, overflow);
    end
    rst = 1'b0; res.ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (res.valid !== 1'b0 || capture !== 1'b0) idle_valid++;
    end
    checks++; if (idle_valid != 0) begin failures++; $display("FAIL mid_idle_after_rst got %0d active cycles want 0", idle_valid); end
    rst = 1'b1;
    present_frame(1300, 1'b0, 1'b1);
    step();
    rst = 1'b0;
    step();
    checks++; if (capture !== 1'b1 || res.data !== W'(1300)) begin
      failures++; $display("FAIL done_high_at_release got cap=%b data=%0h want 1 514", capture, res.data);
    end
    done = 1'b0;
    wait_drain();
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL release_drain left=%0d want 0", sb.size()); end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_back_to_back();
    test_simultaneous();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
